// File: rtl/fft_pkg.sv
// Shared FFT datapath widths and sample/twiddle types.
// Twiddles are Q(TW_W-TW_FRAC).TW_FRAC; ONE is the code for +1.0.
package fft_pkg;
    localparam int DATA_W  = 16;
    localparam int TW_W    = 12;
    localparam int TW_FRAC = 8;
    localparam int ONE     = 1 << TW_FRAC;

    typedef logic signed [DATA_W-1:0] sample_t;
    typedef logic signed [TW_W-1:0]   twiddle_t;

    typedef struct packed {
        sample_t re;
        sample_t im;
    } complex_t;
endpackage

// File: rtl/twiddle_mult_round_sat.sv
// Round-half-up arithmetic right shift followed by two's-complement saturation.
// Latency: combinational.
// Backpressure: none, pure function of i_dat.
module round_sat #(
    parameter int IN_W  = 29,
    parameter int SHIFT = 8,
    parameter int OUT_W = 16
) (
    input  logic signed [IN_W-1:0]  i_dat,
    output logic signed [OUT_W-1:0] o_dat
);
    localparam logic signed [IN_W:0] HALF = (IN_W+1)'(1) << (SHIFT-1);

    logic signed [IN_W:0]       w_sum;
    logic signed [IN_W:0]       w_shr;
    logic [IN_W-OUT_W+1:0]      w_top;

    // One guard bit so adding HALF to the most positive input cannot wrap.
    assign w_sum = {i_dat[IN_W-1], i_dat} + HALF;
    assign w_shr = w_sum >>> SHIFT;
    assign w_top = w_shr[IN_W:OUT_W-1];

    always_comb begin
        o_dat = w_shr[OUT_W-1:0];
        if (!(&w_top) && (|w_top)) begin
            o_dat = w_top[IN_W-OUT_W+1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                        : {1'b0, {(OUT_W-1){1'b1}}};
        end
    end
endmodule

// File: rtl/twiddle_mult.sv
// Streaming complex multiply y = x * W with rounding and saturation.
// Latency: 3 register stages (input, products, round/sat), 1 beat/cycle.
// Backpressure: whole pipe freezes while out_valid & !out_ready; in_ready = !out_valid | out_ready.
module twiddle_mult #(
    parameter int DATA_W  = fft_pkg::DATA_W,
    parameter int TW_W    = fft_pkg::TW_W,
    parameter int TW_FRAC = fft_pkg::TW_FRAC
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_re,
    input  logic signed [DATA_W-1:0] in_im,
    input  logic                     in_last,
    input  logic signed [TW_W-1:0]   tw_cos,
    input  logic signed [TW_W-1:0]   tw_sin,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_re,
    output logic signed [DATA_W-1:0] out_im,
    output logic                     out_last
);
    localparam int PW = DATA_W + TW_W;

    logic                     w_en;
    logic signed [PW:0]       w_p_re;
    logic signed [PW:0]       w_p_im;
    logic signed [DATA_W-1:0] w_r_re;
    logic signed [DATA_W-1:0] w_r_im;

    logic                     r_s1_vld;
    logic                     r_s1_last;
    logic signed [DATA_W-1:0] r_s1_a;
    logic signed [DATA_W-1:0] r_s1_b;
    logic signed [TW_W-1:0]   r_s1_c;
    logic signed [TW_W-1:0]   r_s1_s;

    logic                     r_s2_vld;
    logic                     r_s2_last;
    logic signed [PW-1:0]     r_s2_ac;
    logic signed [PW-1:0]     r_s2_bs;
    logic signed [PW-1:0]     r_s2_as;
    logic signed [PW-1:0]     r_s2_bc;

    logic                     r_out_vld;
    logic                     r_out_last;
    logic signed [DATA_W-1:0] r_out_re;
    logic signed [DATA_W-1:0] r_out_im;

    assign w_en     = !r_out_vld || out_ready;
    assign in_ready = w_en;

    assign w_p_re = (PW+1)'(r_s2_ac) - (PW+1)'(r_s2_bs);
    assign w_p_im = (PW+1)'(r_s2_as) + (PW+1)'(r_s2_bc);

    round_sat #(.IN_W(PW+1), .SHIFT(TW_FRAC), .OUT_W(DATA_W)) u_rs_re (
        .i_dat (w_p_re),
        .o_dat (w_r_re)
    );

    round_sat #(.IN_W(PW+1), .SHIFT(TW_FRAC), .OUT_W(DATA_W)) u_rs_im (
        .i_dat (w_p_im),
        .o_dat (w_r_im)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_vld   <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_c     <= '0;
            r_s1_s     <= '0;
            r_s2_vld   <= 1'b0;
            r_s2_last  <= 1'b0;
            r_s2_ac    <= '0;
            r_s2_bs    <= '0;
            r_s2_as    <= '0;
            r_s2_bc    <= '0;
            r_out_vld  <= 1'b0;
            r_out_last <= 1'b0;
            r_out_re   <= '0;
            r_out_im   <= '0;
        end else if (w_en) begin
            r_s1_vld   <= in_valid;
            r_s1_last  <= in_last;
            r_s1_a     <= in_re;
            r_s1_b     <= in_im;
            r_s1_c     <= tw_cos;
            r_s1_s     <= tw_sin;

            r_s2_vld   <= r_s1_vld;
            r_s2_last  <= r_s1_last;
            r_s2_ac    <= PW'(r_s1_a) * PW'(r_s1_c);
            r_s2_bs    <= PW'(r_s1_b) * PW'(r_s1_s);
            r_s2_as    <= PW'(r_s1_a) * PW'(r_s1_s);
            r_s2_bc    <= PW'(r_s1_b) * PW'(r_s1_c);

            r_out_vld  <= r_s2_vld;
            r_out_last <= r_s2_last;
            r_out_re   <= w_r_re;
            r_out_im   <= w_r_im;
        end
    end

    assign out_valid = r_out_vld;
    assign out_last  = r_out_last;
    assign out_re    = r_out_re;
    assign out_im    = r_out_im;
endmodule
